// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator back-buffer drain path:
// element bitwidth encodings, drain FSM states and a width decoder.
package accum_pkg;

    localparam logic [1:0] BW_2 = 2'd0;
    localparam logic [1:0] BW_4 = 2'd1;
    localparam logic [1:0] BW_8 = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        CAPTURE,
        OUTPUT,
        DONE
    } drain_state_t;

    // Encoding 3 is treated like 0 (2-bit elements).
    function automatic int width_of(input logic [1:0] bitwidth);
        case (bitwidth)
            BW_4:    return 4;
            BW_8:    return 8;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/accumulator_saturate.sv
// Signed saturation of a bank partial sum to the active element width,
// sign-extended to OUT_WIDTH. Purely combinational.
// Build option: define ACCUM_DRAIN_RELU_EN to clamp negative sums to 0
// before saturation.
module accumulator_saturate
    import accum_pkg::*;
#(
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    parameter int OUT_WIDTH              = 8
) (
    input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0] value,
    input  logic [1:0]                          bitwidth,
    output logic [OUT_WIDTH-1:0]                out
);

    localparam int VW = SMALLEST_ELEMENT_WIDTH * 4;

    logic signed [VW-1:0] v;
    logic signed [VW-1:0] hi;
    logic signed [VW-1:0] lo;
    logic signed [VW-1:0] sat;
    int                   w;

    // Clamp to [-2^(W-1), 2^(W-1)-1]; the clamped value fits in W bits, so a
    // signed resize yields the sign-extended element directly.
    always_comb begin
        w  = width_of(bitwidth);
        hi = VW'((1 << (w - 1)) - 1);
        lo = ~hi;
`ifdef ACCUM_DRAIN_RELU_EN
        v  = value[VW-1] ? '0 : $signed(value);
`else
        v  = $signed(value);
`endif
        if (v > hi)      sat = hi;
        else if (v < lo) sat = lo;
        else             sat = v;
        out = OUT_WIDTH'(sat);
    end

endmodule

// File: rtl/accumulator_drain.sv
// Drains every back-buffer bank entry in order, saturates each partial sum
// to the bitwidth latched at start, and streams it over valid/ready.
// Build option: ACCUM_DRAIN_RELU_EN (see accumulator_saturate).
module accumulator_drain
    import accum_pkg::*;
#(
    parameter int BUFFER_WIDTH           = 8,
    parameter int SMALLEST_ELEMENT_WIDTH = 4,
    parameter int OUT_WIDTH              = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [1:0]                          bitwidth,
    output logic [$clog2(BUFFER_WIDTH)-1:0]     bank_entry,
    input  logic [SMALLEST_ELEMENT_WIDTH*4-1:0] bank_data_read,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [OUT_WIDTH-1:0]                out_data,
    output logic [$clog2(BUFFER_WIDTH)-1:0]     out_index,
    output logic                                busy,
    output logic                                done
);

    localparam int            AW   = $clog2(BUFFER_WIDTH);
    localparam logic [AW-1:0] LAST = AW'(BUFFER_WIDTH - 1);

    drain_state_t         state;
    logic [1:0]           bw_lat;
    logic [OUT_WIDTH-1:0] sat_val;

    accumulator_saturate #(
        .SMALLEST_ELEMENT_WIDTH(SMALLEST_ELEMENT_WIDTH),
        .OUT_WIDTH             (OUT_WIDTH)
    ) u_sat (
        .value   (bank_data_read),
        .bitwidth(bw_lat),
        .out     (sat_val)
    );

    // Drain FSM; bank_entry doubles as the entry counter and is held from
    // ADDR through the handshake so the bank read has a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            bank_entry <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bw_lat     <= BW_2;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        bw_lat     <= bitwidth;
                        bank_entry <= '0;
                        busy       <= 1'b1;
                        state      <= ADDR;
                    end
                end
                ADDR: state <= CAPTURE;
                CAPTURE: begin
                    out_data  <= sat_val;
                    out_index <= bank_entry;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (bank_entry == LAST) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bank_entry <= bank_entry + AW'(1);
                            state      <= ADDR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_drain.sv
// Self-checking bench for accumulator_drain: table-driven drain passes with
// a scoreboard of expected {index, data}, plus back-pressure, mid-pass
// start/bitwidth disturbance, mid-pass reset and randomized passes.
module tb_accumulator_drain;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  bitwidth;
    logic [2:0]  bank_entry;
    logic [15:0] bank_data_read;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_index;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    accumulator_drain #(
        .BUFFER_WIDTH(8), .SMALLEST_ELEMENT_WIDTH(4), .OUT_WIDTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .bitwidth(bitwidth),
        .bank_entry(bank_entry), .bank_data_read(bank_data_read),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .busy(busy), .done(done)
    );

    logic [15:0] mem [8];
    assign bank_data_read = mem[bank_entry];

    typedef struct { logic [1:0] bw; logic [15:0] val; logic [7:0] exp; } vec_t;
    typedef struct { logic [2:0] idx; logic [7:0] data; } sb_t;

    vec_t       tbl [24];
    sb_t        sb [$];
    logic [7:0] cur_exp [8];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         done_cnt = 0;
    logic       exp_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] bw, input logic [15:0] raw);
        int v, w, mx, mn;
        v = int'($signed(raw));
        w = (bw == 2'd1) ? 4 : (bw == 2'd2) ? 8 : 2;
`ifdef ACCUM_DRAIN_RELU_EN
        if (v < 0) v = 0;
`endif
        mx = (1 << (w - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        else if (v < mn) v = mn;
        return v[7:0];
    endfunction

    // Scoreboard and done-timing monitor, sampled away from the active edge.
    always @(negedge clk) begin
        sb_t it;
        if (reset_n === 1'b1) begin
            chk("done_timing", {31'd0, done}, {31'd0, exp_done});
            if (done) done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
                else begin
                    it = sb.pop_front();
                    chk("out_index", {29'd0, out_index}, {29'd0, it.idx});
                    chk("out_data", {24'd0, out_data}, {24'd0, it.data});
                end
            end
            exp_done = out_valid && out_ready && (out_index == 3'd7);
        end else begin
            exp_done = 1'b0;
        end
    end

    task automatic load_chunk(input int c, output logic [1:0] bw);
        logic [7:0] e;
        bw = tbl[c*8].bw;
        for (int i = 0; i < 8; i++) begin
            mem[i] = tbl[c*8+i].val;
            e = tbl[c*8+i].exp;
`ifdef ACCUM_DRAIN_RELU_EN
            if (tbl[c*8+i].val[15]) e = 8'h00;
`endif
            cur_exp[i] = e;
        end
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_bank_entry"}, {29'd0, bank_entry}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        chk({tag, "_out_index"}, {29'd0, out_index}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run_pass(input logic [1:0] bw, input int hold_idx, input int rst_idx,
                            input bit disturb, input bit chk_cyc);
        int  cyc, d0;
        bit  aborted, held;
        sb_t it;
        for (int i = 0; i < 8; i++) begin
            it.idx = 3'(i); it.data = cur_exp[i]; sb.push_back(it);
        end
        d0 = done_cnt; aborted = 0; held = 0; cyc = 0;
        @(posedge clk); #1; start = 1'b1; bitwidth = bw;
        @(posedge clk); #1; start = 1'b0;
        while (cyc < 300) begin
            if (!busy) break;
            if (disturb) begin
                bitwidth = 2'($urandom_range(0, 3));
                start = (cyc % 5 == 2) || done;
            end
            if (hold_idx >= 0 && !held && out_valid && out_index == 3'(hold_idx)) begin
                held = 1; out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1; cyc++;
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("hold_index", {29'd0, out_index}, 32'(hold_idx));
                    chk("hold_data", {24'd0, out_data}, {24'd0, cur_exp[hold_idx]});
                    chk("hold_bank_entry", {29'd0, bank_entry}, 32'(hold_idx));
                end
                out_ready = 1'b1;
            end
            if (rst_idx >= 0 && out_valid && out_index == 3'(rst_idx)) begin
                reset_n = 1'b0; out_ready = 1'b0; sb.delete();
                @(posedge clk); #1;
                check_zero_state("midreset");
                reset_n = 1'b1; out_ready = 1'b1; aborted = 1;
                break;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; bitwidth = bw;
        if (cyc >= 300) chk("pass_timeout", 32'd1, 32'd0);
        if (!aborted) begin
            chk("sb_drained", 32'(sb.size()), 32'd0);
            chk("done_pulses", 32'(done_cnt - d0), 32'd1);
            if (chk_cyc) chk("pass_cycles", 32'(cyc), 32'd25);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_pass", {31'd0, busy}, 32'd0);
        if (aborted) chk("no_done_on_reset", 32'(done_cnt - d0), 32'd0);
    endtask

    initial begin
        logic [1:0] bw;
        tbl = '{
            '{2'd1, 16'h0005, 8'h05}, '{2'd1, 16'h0040, 8'h07}, '{2'd1, 16'hFFF0, 8'hF8},
            '{2'd1, 16'h0007, 8'h07}, '{2'd1, 16'hFFF8, 8'hF8}, '{2'd1, 16'h0000, 8'h00},
            '{2'd1, 16'h7FFF, 8'h07}, '{2'd1, 16'h8000, 8'hF8},
            '{2'd2, 16'h0001, 8'h01}, '{2'd2, 16'h007F, 8'h7F}, '{2'd2, 16'hFF80, 8'h80},
            '{2'd2, 16'h0100, 8'h7F}, '{2'd2, 16'hFF7F, 8'h80}, '{2'd2, 16'h0080, 8'h7F},
            '{2'd2, 16'hFFFF, 8'hFF}, '{2'd2, 16'h1234, 8'h7F},
            '{2'd0, 16'h0003, 8'h01}, '{2'd0, 16'h0001, 8'h01}, '{2'd0, 16'h0000, 8'h00},
            '{2'd0, 16'hFFFF, 8'hFF}, '{2'd0, 16'hFFFE, 8'hFE}, '{2'd0, 16'hFFFD, 8'hFE},
            '{2'd0, 16'h0002, 8'h01}, '{2'd0, 16'h8000, 8'hFE}
        };
        for (int i = 0; i < 8; i++) mem[i] = 16'h0;
        reset_n = 1'b0; start = 1'b0; bitwidth = 2'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero_state("reset");
        reset_n = 1'b1;

        // Table-driven passes, one per 8-record chunk.
        for (int c = 0; c < 3; c++) begin
            load_chunk(c, bw);
            run_pass(bw, -1, -1, 0, 1);
        end
        // Back-pressure at entry 2.
        load_chunk(0, bw);
        run_pass(bw, 2, -1, 0, 0);
        // start pulses and bitwidth toggling mid-pass, including during DONE.
        load_chunk(0, bw);
        run_pass(bw, -1, -1, 1, 1);
        // Reset while entry 4 is presented, then a fresh full pass.
        load_chunk(1, bw);
        run_pass(bw, -1, 4, 0, 0);
        run_pass(bw, -1, -1, 0, 1);
        // Randomized contents across all bitwidth encodings.
        for (int p = 0; p < 4; p++) begin
            bw = 2'(p);
            for (int i = 0; i < 8; i++) begin
                mem[i] = 16'($urandom);
                cur_exp[i] = model(bw, mem[i]);
            end
            run_pass(bw, -1, -1, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
